// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Tracks X/M/W destinations and drives stalls, squashes and forwarding.
module hazard_ctrl #(
    parameter int RF_IDX_WIDTH = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    d_vld,
    input  logic [RF_IDX_WIDTH-1:0] d_rs1,
    input  logic [RF_IDX_WIDTH-1:0] d_rs2,
    input  logic                    d_rs1_used,
    input  logic                    d_rs2_used,
    input  logic [RF_IDX_WIDTH-1:0] d_rd,
    input  logic                    d_wr_en,
    input  logic                    d_is_load,
    input  logic                    x_redirect,
    input  logic                    imem_rsp_vld,
    input  logic                    dmem_wait,
    output logic                    f_en,
    output logic                    d_en,
    output logic                    d_squash,
    output logic                    x_bubble,
    output logic [1:0]              fwd_sel_rs1,
    output logic [1:0]              fwd_sel_rs2,
    output logic [CNT_WIDTH-1:0]    stall_cycles
);

    typedef struct packed {
        logic                    vld;
        logic                    wr_en;
        logic                    is_load;
        logic [RF_IDX_WIDTH-1:0] rd;
    } sb_t;

    typedef enum logic [2:0] {
        MODE_NORM,
        MODE_GAP,
        MODE_LDU,
        MODE_REDIR,
        MODE_MEM
    } mode_t;

    sb_t   x_q, m_q, w_q;
    sb_t   x_d, m_d, w_d;
    mode_t mode;
    logic  load_use;
    logic  stall_evt;

    function automatic logic hit(sb_t e, logic [RF_IDX_WIDTH-1:0] rs);
        return e.vld & e.wr_en & (e.rd == rs) & (rs != '0);
    endfunction

    // Load data is not ready in X, so an X load never forwards.
    function automatic logic [1:0] fsel(sb_t x, sb_t m, sb_t w,
                                        logic [RF_IDX_WIDTH-1:0] rs);
        if (hit(x, rs) && !x.is_load) return 2'd1;
        else if (hit(m, rs))          return 2'd2;
        else if (hit(w, rs))          return 2'd3;
        else                          return 2'd0;
    endfunction

    assign load_use = d_vld & x_q.is_load &
                      ((d_rs1_used & hit(x_q, d_rs1)) |
                       (d_rs2_used & hit(x_q, d_rs2)));

    always_comb begin
        mode = MODE_NORM;
        priority case (1'b1)
            dmem_wait:     mode = MODE_MEM;
            x_redirect:    mode = MODE_REDIR;
            load_use:      mode = MODE_LDU;
            !imem_rsp_vld: mode = MODE_GAP;
            default:       mode = MODE_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            m_q          <= '0;
            w_q          <= '0;
            stall_cycles <= '0;
        end else begin
            x_q <= x_d;
            m_q <= m_d;
            w_q <= w_d;
            if (stall_evt && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        x_d = x_q;
        m_d = m_q;
        w_d = w_q;
        unique case (mode)
            MODE_MEM: begin
                w_d = '0;
            end
            MODE_REDIR, MODE_LDU: begin
                x_d = '0;
                m_d = x_q;
                w_d = m_q;
            end
            default: begin
                x_d = '{vld: d_vld, wr_en: d_wr_en,
                        is_load: d_is_load, rd: d_rd};
                m_d = x_q;
                w_d = m_q;
            end
        endcase
    end

    always_comb begin
        f_en        = 1'b1;
        d_en        = 1'b1;
        d_squash    = 1'b0;
        x_bubble    = 1'b0;
        fwd_sel_rs1 = fsel(x_q, m_q, w_q, d_rs1);
        fwd_sel_rs2 = fsel(x_q, m_q, w_q, d_rs2);
        unique case (mode)
            MODE_MEM: begin
                f_en = 1'b0;
                d_en = 1'b0;
            end
            MODE_REDIR: begin
                d_squash = 1'b1;
                x_bubble = 1'b1;
            end
            MODE_LDU: begin
                f_en     = 1'b0;
                d_en     = 1'b0;
                x_bubble = 1'b1;
            end
            MODE_GAP: begin
                f_en     = 1'b0;
                d_squash = 1'b1;
            end
            default: begin
                f_en = 1'b1;
            end
        endcase
        // Inputs may still toggle in reset; present a quiet pipeline.
        if (!rst_n) begin
            f_en        = 1'b1;
            d_en        = 1'b1;
            d_squash    = 1'b0;
            x_bubble    = 1'b0;
            fwd_sel_rs1 = 2'd0;
            fwd_sel_rs2 = 2'd0;
        end
    end

    assign stall_evt = !d_en | x_bubble;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl.
// Each vector is one cycle: inputs plus expected outputs before the edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_vld;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_rs1_used, d_rs2_used;
    logic        d_wr_en, d_is_load;
    logic        x_redirect, imem_rsp_vld, dmem_wait;
    logic        f_en, d_en, d_squash, x_bubble;
    logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       vld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       redir;
        logic       imem;
        logic       dmem;
        logic       ef;
        logic       ed;
        logic       esq;
        logic       exb;
        logic [1:0] ef1;
        logic [1:0] ef2;
        int         esc;
    } vec_t;

    vec_t vecs[16];

    hazard_ctrl #(.RF_IDX_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .d_vld(d_vld),
        .d_rs1(d_rs1),
        .d_rs2(d_rs2),
        .d_rs1_used(d_rs1_used),
        .d_rs2_used(d_rs2_used),
        .d_rd(d_rd),
        .d_wr_en(d_wr_en),
        .d_is_load(d_is_load),
        .x_redirect(x_redirect),
        .imem_rsp_vld(imem_rsp_vld),
        .dmem_wait(dmem_wait),
        .f_en(f_en),
        .d_en(d_en),
        .d_squash(d_squash),
        .x_bubble(x_bubble),
        .fwd_sel_rs1(fwd_sel_rs1),
        .fwd_sel_rs2(fwd_sel_rs2),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        d_vld        = v.vld;
        d_rs1        = v.rs1;
        d_rs1_used   = v.u1;
        d_rs2        = v.rs2;
        d_rs2_used   = v.u2;
        d_rd         = v.rd;
        d_wr_en      = v.wr;
        d_is_load    = v.ld;
        x_redirect   = v.redir;
        imem_rsp_vld = v.imem;
        dmem_wait    = v.dmem;
    endtask

    task automatic apply(input vec_t v, input string nm, input bit adv);
        drive(v);
        #2;
        chk({nm, "_ctl"},
            32'({f_en, d_en, d_squash, x_bubble, fwd_sel_rs1, fwd_sel_rs2}),
            32'({v.ef, v.ed, v.esq, v.exb, v.ef1, v.ef2}));
        chk({nm, "_cnt"}, 32'(stall_cycles), 32'(v.esc));
        if (adv) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t v;

    initial begin
        vecs[0]  = '{0,  0,0,  0,0,  0,0,0, 0,1,0, 1,1,0,0, 0,0, 0};
        vecs[1]  = '{1,  1,1,  0,0,  5,1,0, 0,1,0, 1,1,0,0, 0,0, 0};
        vecs[2]  = '{1,  5,1,  5,1,  6,1,0, 0,1,0, 1,1,0,0, 1,1, 0};
        vecs[3]  = '{1,  5,1,  6,1,  7,1,0, 0,1,0, 1,1,0,0, 2,1, 0};
        vecs[4]  = '{1,  5,1,  0,0,  8,1,1, 0,1,0, 1,1,0,0, 3,0, 0};
        vecs[5]  = '{1,  8,1,  7,1,  9,1,0, 0,1,0, 0,0,0,1, 0,2, 0};
        vecs[6]  = '{1,  8,1,  7,1,  9,1,0, 0,1,0, 1,1,0,0, 2,3, 1};
        vecs[7]  = '{1,  9,1,  0,0,  0,1,0, 0,1,0, 1,1,0,0, 1,0, 1};
        vecs[8]  = '{1,  0,1,  0,1,  0,1,1, 0,1,0, 1,1,0,0, 0,0, 1};
        vecs[9]  = '{1,  0,1,  9,1, 10,1,0, 0,1,0, 1,1,0,0, 0,3, 1};
        vecs[10] = '{1, 10,1,  0,0, 11,1,1, 0,1,0, 1,1,0,0, 1,0, 1};
        vecs[11] = '{1, 11,1,  0,0, 12,1,0, 1,1,0, 1,1,1,1, 0,0, 1};
        vecs[12] = '{1, 10,1, 11,1, 13,1,0, 0,1,0, 1,1,0,0, 3,2, 2};
        vecs[13] = '{1, 13,1,  0,0, 14,1,0, 0,0,0, 0,1,1,0, 1,0, 2};
        vecs[14] = '{0, 14,1,  0,0,  0,0,0, 0,0,0, 0,1,1,0, 1,0, 2};
        vecs[15] = '{0, 14,1, 13,1,  0,0,0, 0,1,0, 1,1,0,0, 2,3, 2};

        // Hazard-provoking inputs held during reset must be masked.
        rst_n = 1'b0;
        v = '{1, 5,1, 5,1, 5,1,1, 1,0,1, 1,1,0,0, 0,0, 0};
        apply(v, "reset", 1'b1);
        do_reset();

        for (int i = 0; i < 16; i++)
            apply(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // dmem_wait for 3 cycles with a redirect pending and lw x15 in M.
        do_reset();
        v = '{1,  0,0,  0,0, 20,1,0, 0,1,0, 1,1,0,0, 0,0, 0};
        apply(v, "mem_pre0", 1'b1);
        v = '{1,  0,0,  0,0, 15,1,1, 0,1,0, 1,1,0,0, 0,0, 0};
        apply(v, "mem_pre1", 1'b1);
        v = '{1,  0,0,  0,0, 16,1,0, 0,1,0, 1,1,0,0, 0,0, 0};
        apply(v, "mem_pre2", 1'b1);
        v = '{1, 20,1, 15,1, 21,1,0, 1,1,1, 0,0,0,0, 3,2, 0};
        apply(v, "mem_s1", 1'b1);
        v = '{1, 20,1, 15,1, 21,1,0, 1,1,1, 0,0,0,0, 0,2, 1};
        apply(v, "mem_s2", 1'b1);
        v = '{1, 20,1, 15,1, 21,1,0, 1,1,1, 0,0,0,0, 0,2, 2};
        apply(v, "mem_s3", 1'b1);
        v = '{1, 20,1, 15,1, 21,1,0, 1,1,0, 1,1,1,1, 0,2, 3};
        apply(v, "mem_redir", 1'b1);

        // Fetch gap, then async reset in the middle of the cycle.
        v = '{1, 16,1, 15,1, 22,1,0, 0,0,0, 0,1,1,0, 2,3, 4};
        apply(v, "gap_pre", 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl",
            32'({f_en, d_en, d_squash, x_bubble, fwd_sel_rs1, fwd_sel_rs2}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0}));
        chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{1, 16,1, 15,1, 22,1,0, 0,0,0, 0,1,1,0, 0,0, 0};
        apply(v, "gap_post", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
